fifo_write_arbiter: RTL
=======================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of one fifo instance between NREQ
//  requesters (protocol engines, host command path). Each requester presents packets
//  with a valid/ready/last handshake. A grant is held for a whole packet, so packets
//  never interleave in the fifo. The block drives fifo in_shift/in_data and obeys in_full.
// PARAMETERS
//  NREQ      4   number of requesters, 2..8
//  WIDTH     8   data word width; must match the fifo WIDTH
//  MAXBURST  16  max words per grant; grant is released after this many words even without last
// PORTS
//  clock          in   1           system clock, rising edge
//  reset_n        in   1           asynchronous reset, active low
//  req_valid      in   NREQ        requester i has a word on req_data[i]
//  req_data       in   NREQ*WIDTH  word i occupies bits [i*WIDTH +: WIDTH]
//  req_last       in   NREQ        word i is the final word of its packet
//  req_ready      out  NREQ        word i is accepted this cycle (valid & ready = transfer)
//  grant          out  NREQ        one-hot registered grant; all zero when idle
//  busy           out  1           high while in GRANT state
//  fifo_in_shift  out  1           write strobe to the fifo
//  fifo_in_data   out  WIDTH       write data to the fifo
//  fifo_in_full   in   1           fifo full; no write may be issued while high
//  stat_clear     in   1           [ARB_STATS_EN only] synchronously zero all counters
//  stat_count     out  NREQ*16     [ARB_STATS_EN only] words accepted per requester
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, grant=0, busy=0, beat=0, rr_ptr=NREQ-1
//    (requester 0 wins first). req_ready=0 and fifo_in_shift=0 while reset is held.
//  - IDLE: if any req_valid, choose first valid index searching rr_ptr+1, rr_ptr+2, ...
//    (mod NREQ). Register grant, set beat=0, go to GRANT. 1-cycle arbitration bubble;
//    nothing is written in IDLE.
//  - GRANT, g = granted index: xfer = req_valid[g] & ~fifo_in_full.
//    req_ready[g] = ~fifo_in_full (combinational); other req_ready bits = 0.
//    fifo_in_shift = xfer; fifo_in_data = req_data[g]. Zero-latency passthrough.
//  - On xfer: beat <= beat+1. If req_last[g], or beat==MAXBURST-1: go to IDLE,
//    set rr_ptr=g, clear grant.
//  - Granted requester dropping valid mid-packet: grant is held (packet lock). No
//    timeout. Others wait.
//  - fifo_in_full high: no write and no beat change. Grant is held. Valid may stay
//    high indefinitely.
//  - Simultaneous requests: strict round robin. A requester that just released the
//    grant has lowest priority next arbitration.
//  - beat width = $clog2(MAXBURST)+1. With MAXBURST=1 every word is its own grant.
//  - req_valid for a non-granted index has no effect on outputs.
//  - Reset asserted mid-packet: grant drops immediately (async). The partial packet
//    stays in the fifo; the consumer is responsible for it.
// CONFIGURATION
//  ARB_STATS_EN defined:
//  - stat_clear and stat_count ports exist.
//  - Per requester, a 16-bit counter increments on each xfer of that requester and
//    saturates at 16'hFFFF.
//  - stat_clear zeroes all counters next edge and has priority over a same-cycle
//    increment.
//  - Counters reset to 0.
//  ARB_STATS_EN undefined:
//  - Those ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset release, req_valid=4'b0001, 3-word packet A1,A2,A3(last), full=0
//     -> grant=0001 one cycle after valid; shifts A1..A3 on 3 consecutive cycles;
//     grant=0 after A3.
//  2. All four valid, 2-word packets each
//     -> grant order 0,1,2,3,0. Each packet is contiguous in the fifo with 1 idle
//     cycle between packets.
//  3. Grant to 1, fifo_in_full high for 5 cycles mid-packet
//     -> fifo_in_shift=0 and req_ready=0 for those 5 cycles; the same word is
//     written once full drops; grant unchanged.
//  4. Requester 2 streams 40 words with no last, MAXBURST=16, requester 3 also valid
//     -> 16 words from 2, then grant to 3, then 2 resumes at word 17.
//  5. reset_n pulsed low during word 2 of a 4-word packet
//     -> grant=0, fifo_in_shift=0 immediately. After release, requester 0 is
//     arbitrated first.
//  6. [ARB_STATS_EN] 300 words from requester 1, then stat_clear with a same-cycle
//     xfer -> stat_count[1]=300, then 0 the next cycle.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Requester/fifo write-port bundle shared by the arbiter and its environment.
// master = requesters + fifo side, slave = the arbiter.
interface fifo_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_last;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            grant;
  logic                       busy;
  logic                       fifo_in_shift;
  logic [WIDTH-1:0]           fifo_in_data;
  logic                       fifo_in_full;

  modport master (
    output req_valid, req_data, req_last, fifo_in_full,
    input  req_ready, grant, busy, fifo_in_shift, fifo_in_data
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_in_full,
    output req_ready, grant, busy, fifo_in_shift, fifo_in_data
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Packet-locked round-robin arbiter for a single fifo write port.
// Define ARB_STATS_EN to add per-requester saturating word counters.
module fifo_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAXBURST = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  fifo_write_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  input  logic                  stat_clear_i,
  output logic [NREQ-1:0][15:0] stat_count_o
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAXBURST) + 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [IW-1:0]   pick;
  logic            any_vld;
  logic            xfer, done;

  logic [NREQ-1:0]  ready;
  logic             shift;
  logic [WIDTH-1:0] wdata;

  // Scan farthest-to-nearest so the nearest valid index after rr_q wins.
  always_comb begin
    int idx;
    pick    = '0;
    any_vld = 1'b0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        pick    = IW'(idx);
        any_vld = 1'b1;
      end
    end
  end

  assign xfer = (state_q == GRANT) && bus.req_valid[gidx_q] && !bus.fifo_in_full;
  assign done = xfer && (bus.req_last[gidx_q] || (beat_q == BW'(MAXBURST - 1)));

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= IW'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: if (any_vld) begin
        state_d       = GRANT;
        grant_d       = '0;
        grant_d[pick] = 1'b1;
        gidx_d        = pick;
        beat_d        = '0;
      end
      GRANT: begin
        if (xfer) beat_d = beat_q + BW'(1);
        if (done) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = gidx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Granted requester is passed straight through to the fifo port.
  always_comb begin
    ready = '0;
    shift = 1'b0;
    wdata = '0;
    if (state_q == GRANT) begin
      ready[gidx_q] = !bus.fifo_in_full;
      shift         = xfer;
      wdata         = bus.req_data[gidx_q];
    end
  end

  assign bus.req_ready     = ready;
  assign bus.fifo_in_shift = shift;
  assign bus.fifo_in_data  = wdata;
  assign bus.grant         = grant_q;
  assign bus.busy          = (state_q == GRANT);

`ifdef ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [15:0] cnt_q;
    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i)                                            cnt_q <= '0;
      else if (stat_clear_i)                                     cnt_q <= '0;
      else if (xfer && gidx_q == IW'(i) && cnt_q != 16'hFFFF)    cnt_q <= cnt_q + 16'd1;
    end
    assign stat_count_o[i] = cnt_q;
  end
`endif
endmodule
